// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: default datapath width, fetch stride,
// reset vector and the prefetcher's fetch-control state encoding.
package rv32i_pkg;

  localparam int unsigned     XLEN_DEFAULT     = 32;
  localparam int unsigned     FETCH_STRIDE     = 4;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

  // FS_TRAP_WAIT: misaligned target seen, waiting for stale responses to drain
  // before the trap marker is queued. FS_HALTED: marker queued, no fetching.
  typedef enum logic [1:0] {
    FS_FETCH     = 2'd0,
    FS_TRAP_WAIT = 2'd1,
    FS_HALTED    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Fetch queue: synchronous FIFO with flush, supports push+pop when full.
// Ports: clk, rst (async, active-high), flush (empties the queue this edge),
//        push/wdata, pop, rdata (head entry), count (occupancy), empty.
module if_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot the same edge, so a full queue may still accept.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: issues sequential fetches, queues returned
// words with their PCs, drops stale responses after a redirect and turns a
// misaligned redirect target into a single trap-marker entry.
// Ports: clk, rst (async, active-high); redirect/redirect_pc (jump);
//        imem_req_valid/ready/addr (fetch request); imem_resp_valid/data
//        (in-order response); dec_valid/ready, dec_inst, dec_pc, dec_pc4,
//        dec_misaligned (decode-side head entry).
module if_prefetch
  import rv32i_pkg::*;
#(
  parameter int unsigned      XLEN       = XLEN_DEFAULT,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned      ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [XLEN-1:0]   imem_resp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [XLEN-1:0]   dec_inst,
  output logic [XLEN-1:0]   dec_pc,
  output logic [XLEN-1:0]   dec_pc4,
  output logic              dec_misaligned
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam int unsigned     EW         = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] STRIDE     = XLEN'(FETCH_STRIDE);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_n;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    occupancy;
  logic [CW:0]      inflight;
  logic             halted;
  logic             trap_push;
  logic             target_misaligned;
  logic             accept;
  logic             resp_keep;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head_entry;

  assign target_misaligned = (redirect_pc & ALIGN_MASK) != '0;
  // Queue slots are reserved for every in-flight request so a response can
  // always be pushed.
  assign inflight  = {1'b0, occupancy} + {1'b0, outstanding};
  assign accept    = imem_req_valid && imem_req_ready;
  assign resp_keep = imem_resp_valid && !redirect && (drop_cnt == '0);
  assign push      = resp_keep || trap_push;
  assign pop       = dec_ready && !fifo_empty;
  assign push_entry = resp_keep ? {imem_resp_data, resp_pc, 1'b0}
                                : {{XLEN{1'b0}}, resp_pc, 1'b1};

  // Fetch-control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FS_FETCH;
    else     state <= state_n;
  end

  // Next-state: every redirect restarts; a pending trap waits for the drain.
  always_comb begin
    state_n = state;
    if (redirect) begin
      state_n = target_misaligned ? FS_TRAP_WAIT : FS_FETCH;
    end else if ((state == FS_TRAP_WAIT) && (drop_cnt == '0)) begin
      state_n = FS_HALTED;
    end
  end

  // Control outputs derived from state.
  always_comb begin
    halted         = (state != FS_FETCH);
    trap_push      = (state == FS_TRAP_WAIT) && (drop_cnt == '0) && !redirect;
    imem_req_valid = !rst && !redirect && !halted && (inflight < DEPTH_W);
  end

  // Fetch PC, PC of the next kept response, in-flight and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect)    fetch_pc <= redirect_pc;
      else if (accept) fetch_pc <= fetch_pc + STRIDE;

      // Responses come back in order, so the next kept one belongs to the
      // oldest live request: redirect target, then successive strides.
      if (redirect)       resp_pc <= redirect_pc;
      else if (resp_keep) resp_pc <= resp_pc + STRIDE;

      case ({accept, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase

      // Everything still in flight at a redirect is stale.
      if (redirect) begin
        drop_cnt <= imem_resp_valid ? outstanding - CW'(1) : outstanding;
      end else if (imem_resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (occupancy),
    .empty (fifo_empty)
  );

  assign imem_req_addr  = fetch_pc;
  assign dec_valid      = !fifo_empty;
  assign dec_inst       = head_entry[EW-1 -: XLEN];
  assign dec_pc         = head_entry[XLEN:1];
  assign dec_misaligned = dec_valid && head_entry[0];
  assign dec_pc4        = dec_pc + STRIDE;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: two instances (ALIGN_BITS 2 and 1) share clock,
// reset, redirect and handshake stimulus; each has its own in-order memory
// model and a scoreboard of the expected decode stream.
module tb_if_prefetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  localparam int MEM_FIXED  = 0;  // respond every cycle something is pending
  localparam int MEM_HOLD   = 1;  // respond never
  localparam int MEM_RANDOM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        dec_ready;
  int          mem_mode;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input int lane_id, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got 0x%08h expected 0x%08h (t=%0t)",
               lane_id, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned AB    = (g == 0) ? 2 : 1;
    localparam logic [31:0] AMASK = (g == 0) ? 32'h3 : 32'h1;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;
    logic        dec_misaligned;

    exp_t        sb[$];
    logic [31:0] mq[$];
    logic [31:0] mpc      = 32'h0;
    bit          halted_m = 1'b0;
    int          n_xfer   = 0;

    if_prefetch #(
      .XLEN       (32),
      .DEPTH      (4),
      .RESET_PC   (32'h0),
      .ALIGN_BITS (AB)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_inst        (dec_inst),
      .dec_pc          (dec_pc),
      .dec_pc4         (dec_pc4),
      .dec_misaligned  (dec_misaligned)
    );

    // In-order memory: answers the oldest pending address, at least one
    // cycle after it was accepted.
    always begin
      @(posedge clk);
      #1;
      if (mq.size() != 0 &&
          (mem_mode == MEM_FIXED ||
           (mem_mode == MEM_RANDOM && $urandom_range(2) != 0))) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0]);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
    end

    // Monitor: inputs are stable here, so each handshake seen now takes
    // effect at the next rising edge.
    always @(negedge clk) begin
      if (rst) begin
        chk(g, "rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk(g, "rst_dec_valid", 32'(dec_valid), 32'd0);
        chk(g, "rst_dec_misaligned", 32'(dec_misaligned), 32'd0);
        sb.delete();
        mq.delete();
        mpc      = 32'h0;
        halted_m = 1'b0;
      end else begin
        if (dec_valid) begin
          if (sb.size() == 0) begin
            chk(g, "dec_valid_unexpected", 32'(dec_valid), 32'd0);
          end else begin
            chk(g, "dec_pc", dec_pc, sb[0].pc);
            chk(g, "dec_pc4", dec_pc4, sb[0].pc + 32'd4);
            chk(g, "dec_inst", dec_inst, sb[0].inst);
            chk(g, "dec_misaligned", 32'(dec_misaligned), 32'(sb[0].mis));
          end
        end
        if (imem_resp_valid) void'(mq.pop_front());
        if (redirect) begin
          chk(g, "req_in_redirect", 32'(imem_req_valid), 32'd0);
          sb.delete();
          mpc      = redirect_pc;
          halted_m = (redirect_pc & AMASK) != 32'h0;
          if (halted_m) sb.push_back('{pc: redirect_pc, inst: 32'h0, mis: 1'b1});
        end else begin
          if (halted_m) chk(g, "req_while_halted", 32'(imem_req_valid), 32'd0);
          if (dec_valid && dec_ready && sb.size() != 0) begin
            void'(sb.pop_front());
            n_xfer++;
          end
          if (imem_req_valid && imem_req_ready) begin
            chk(g, "req_addr", imem_req_addr, mpc);
            sb.push_back('{pc: mpc, inst: mem_word(mpc), mis: 1'b0});
            mq.push_back(imem_req_addr);
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    mem_mode       = MEM_FIXED;
    repeat (3) tick();

    // Reset release, always-ready memory with 1-cycle responses.
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    @(negedge clk);
    chk(0, "lat_cycle0_dec_valid", 32'(lane[0].dec_valid), 32'd0);
    chk(0, "lat_cycle0_req_valid", 32'(lane[0].imem_req_valid), 32'd1);
    @(negedge clk);
    chk(0, "lat_cycle1_dec_valid", 32'(lane[0].dec_valid), 32'd0);
    @(negedge clk);
    chk(0, "lat_cycle2_dec_valid", 32'(lane[0].dec_valid), 32'd1);
    chk(0, "first_dec_pc", lane[0].dec_pc, 32'h0);
    chk(0, "first_dec_pc4", lane[0].dec_pc4, 32'h4);
    repeat (6) tick();

    // Decode stall: queue fills to DEPTH, requests stop, head holds.
    dec_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk(0, "stall_occupancy", 32'(lane[0].u_dut.occupancy), 32'd4);
    chk(0, "stall_req_valid", 32'(lane[0].imem_req_valid), 32'd0);
    chk(1, "stall_occupancy", 32'(lane[1].u_dut.occupancy), 32'd4);
    tick();
    dec_ready = 1'b1;
    repeat (8) tick();

    // Redirect with exactly two requests held in the memory.
    imem_req_ready = 1'b0;
    repeat (4) tick();
    mem_mode       = MEM_HOLD;
    imem_req_ready = 1'b1;
    repeat (2) tick();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    chk(0, "outstanding_at_redirect", 32'(lane[0].u_dut.outstanding), 32'd2);
    tick();
    redirect       = 1'b0;
    mem_mode       = MEM_FIXED;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk(0, "after_drop_dec_pc", lane[0].dec_pc, 32'h0000_0100);
    tick();
    dec_ready = 1'b1;
    repeat (6) tick();

    // Target 0x102: trap marker at ALIGN_BITS=2, normal fetch at ALIGN_BITS=1.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    dec_ready   = 1'b0;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk(0, "trap_dec_valid", 32'(lane[0].dec_valid), 32'd1);
    chk(0, "trap_dec_misaligned", 32'(lane[0].dec_misaligned), 32'd1);
    chk(0, "trap_dec_pc", lane[0].dec_pc, 32'h0000_0102);
    chk(0, "trap_occupancy", 32'(lane[0].u_dut.occupancy), 32'd1);
    chk(1, "align1_dec_pc", lane[1].dec_pc, 32'h0000_0102);
    chk(1, "align1_dec_misaligned", 32'(lane[1].dec_misaligned), 32'd0);
    tick();
    dec_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk(0, "halted_dec_valid", 32'(lane[0].dec_valid), 32'd0);
    chk(0, "halted_req_valid", 32'(lane[0].imem_req_valid), 32'd0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    dec_ready   = 1'b0;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk(0, "resume_dec_pc", lane[0].dec_pc, 32'h0000_0200);
    chk(0, "resume_dec_misaligned", 32'(lane[0].dec_misaligned), 32'd0);
    tick();
    dec_ready = 1'b1;
    repeat (6) tick();

    // Wrap of the fetch PC.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    dec_ready   = 1'b0;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk(0, "wrap_dec_pc", lane[0].dec_pc, 32'hFFFF_FFFC);
    chk(0, "wrap_dec_pc4", lane[0].dec_pc4, 32'h0000_0000);
    tick();
    dec_ready = 1'b1;
    repeat (10) tick();

    // Random handshakes, latencies and redirects.
    mem_mode = MEM_RANDOM;
    for (int i = 0; i < 2000; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      dec_ready      = ($urandom_range(2) != 0);
      redirect       = ($urandom_range(39) == 0);
      case ($urandom_range(4))
        0:       redirect_pc = $urandom & 32'hFFFF_FFFC;
        1:       redirect_pc = 32'hFFFF_FFF8;
        2:       redirect_pc = ($urandom & 32'h0000_FFFC) | 32'h2;
        3:       redirect_pc = ($urandom & 32'h0000_FFFC) | 32'h1;
        default: redirect_pc = 32'h0000_1000;
      endcase
      tick();
    end

    // Settle on an aligned stream and confirm traffic actually flowed.
    mem_mode       = MEM_FIXED;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk(0, "enough_transfers", 32'(lane[0].n_xfer >= 150), 32'd1);
    chk(1, "enough_transfers", 32'(lane[1].n_xfer >= 150), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
